// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder: WIDTH-bit ripple add, CHUNK bits per cycle, LSB chunk first; subtract mode under ADDER_SUB_EN.
// Latency: accept at edge T, chunk j written at edge T+1+j, out_valid from edge T+N (N = WIDTH/CHUNK).
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             ovf
);
    // WIDTH must be an exact multiple of CHUNK.
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic             c_out;
        logic             ovf;
    } res_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    res_t             res_q;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             carry_nxt;
    logic             msb_cin;

`ifdef ADDER_SUB_EN
    // Subtract as a + ~b + 1: invert at latch time so the datapath stays add-only.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : c0;
`else
    assign b_eff   = b;
    assign cin_eff = c0;
`endif

    assign last = (k_q == K_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign a_chunk = a_q[int'(k_q)*CHUNK +: CHUNK];
    assign b_chunk = b_q[int'(k_q)*CHUNK +: CHUNK];
    assign {carry_nxt, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk MSB recovered from the MSB sum bit; only meaningful on the last chunk.
    assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum_chunk[CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= cin_eff;
            k_q     <= '0;
            res_q.f <= '0;
        end else if (state == RUN) begin
            res_q.f[int'(k_q)*CHUNK +: CHUNK] <= sum_chunk;
            carry_q <= carry_nxt;
            k_q     <= k_q + KW'(1);
            if (last) begin
                res_q.c_out <= carry_nxt;
                res_q.ovf   <= msb_cin ^ carry_nxt;
            end
        end
    end

    assign f     = res_q.f;
    assign c_out = res_q.c_out;
    assign ovf   = res_q.ovf;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: a 16/4 instance and an 8/8 (single-chunk) instance,
// checked every cycle against an arithmetic reference plus hand-computed directed vectors.
module tb_chunk_serial_adder;
`ifdef ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       in_valid, out_ready, c0_in, sub_in;
    logic [1:0][15:0] a_in, b_in;
    logic [1:0]       in_ready, out_valid, c_out, ovf;
    logic [15:0]      f0;
    logic [7:0]       f1;
    logic [1:0][15:0] f_v;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    assign f_v[0] = f0;
    assign f_v[1] = {8'h00, f1};

    chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_in[0]), .b(b_in[0]), .c0(c0_in[0]),
`ifdef ADDER_SUB_EN
        .sub(sub_in[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .f(f0), .c_out(c_out[0]), .ovf(ovf[0])
    );

    chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_in[1][7:0]), .b(b_in[1][7:0]), .c0(c0_in[1]),
`ifdef ADDER_SUB_EN
        .sub(sub_in[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .f(f1), .c_out(c_out[1]), .ovf(ovf[1])
    );

    function automatic int wid(int d);  return (d == 0) ? 16 : 8; endfunction
    function automatic int chk_w(int d); return (d == 0) ? 4 : 8;  endfunction
    function automatic int nn(int d);   return wid(d) / chk_w(d);  endfunction

    // Reference result {ovf, c_out, f} from plain integer arithmetic.
    function automatic logic [17:0] ref_add(int d, logic [15:0] x, logic [15:0] y, logic cin, logic s);
        longint unsigned mask, xx, yy, sum, fr;
        logic c, o, xm, ym, fm;
        int w;
        w    = wid(d);
        mask = (64'd1 << w) - 64'd1;
        xx   = longint'(x) & mask;
        yy   = s ? (~longint'(y) & mask) : (longint'(y) & mask);
        sum  = xx + yy + ((s || cin) ? 64'd1 : 64'd0);
        fr   = sum & mask;
        c    = sum[w];
        xm   = xx[w-1];
        ym   = yy[w-1];
        fm   = fr[w-1];
        o    = (xm == ym) && (fm != xm);
        return {o, c, fr[15:0]};
    endfunction

    function automatic logic [15:0] vis_mask(int d, int cnt);
        int bits;
        bits = cnt * chk_w(d);
        if (bits >= 16) return 16'hFFFF;
        return 16'((32'd1 << bits) - 32'd1);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h, required %h", nm, act, exp);
        end
    endtask

    // Timeline model: edges since accept, whether an operation is outstanding, and its result.
    bit          m_busy [2];
    int          m_cnt  [2];
    logic [15:0] m_f    [2];
    logic        m_c    [2];
    logic        m_o    [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] <= 1'b0;
                m_cnt[d]  <= 0;
                m_f[d]    <= '0;
                m_c[d]    <= 1'b0;
                m_o[d]    <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_busy[d]) begin
                    if (in_valid[d]) begin
                        m_busy[d] <= 1'b1;
                        m_cnt[d]  <= 0;
                        {m_o[d], m_c[d], m_f[d]} <= ref_add(d, a_in[d], b_in[d], c0_in[d], sub_in[d]);
                    end
                end else if (m_cnt[d] < nn(d)) begin
                    m_cnt[d] <= m_cnt[d] + 1;
                end else if (out_ready[d]) begin
                    m_busy[d] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic exp_vld;
            exp_vld = m_busy[d] && (m_cnt[d] == nn(d));
            check($sformatf("d%0d_in_ready", d), 32'(in_ready[d]), 32'(!m_busy[d]));
            check($sformatf("d%0d_out_valid", d), 32'(out_valid[d]), 32'(exp_vld));
            check($sformatf("d%0d_f", d), 32'(f_v[d]), 32'(m_f[d] & vis_mask(d, m_cnt[d])));
            if (exp_vld) begin
                check($sformatf("d%0d_c_out", d), 32'(c_out[d]), 32'(m_c[d]));
                check($sformatf("d%0d_ovf", d), 32'(ovf[d]), 32'(m_o[d]));
            end
        end
    end

    task automatic issue(int d, logic [15:0] x, logic [15:0] y, logic cin, logic s);
        int guard;
        guard = 0;
        @(negedge clk); #1;
        a_in[d]     = x;
        b_in[d]     = y;
        c0_in[d]    = cin;
        sub_in[d]   = s & SUB_EN;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 32'(guard), 32'd0);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        sub_in[d]   = 1'b0;
    endtask

    // Called #1 after the accept edge; counts edges until out_valid.
    task automatic wait_valid(int d, string nm, logic [15:0] ef, logic ec, logic eo);
        int lat;
        lat = 0;
        while (!out_valid[d] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(nn(d)));
        check({nm, "_f"}, 32'(f_v[d]), 32'(ef));
        check({nm, "_c_out"}, 32'(c_out[d]), 32'(ec));
        check({nm, "_ovf"}, 32'(ovf[d]), 32'(eo));
        check({nm, "_model_f"}, 32'(m_f[d]), 32'(ef));
    endtask

    task automatic handoff(int d, string nm);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check({nm, "_in_ready_after"}, 32'(in_ready[d]), 32'd1);
        check({nm, "_out_valid_after"}, 32'(out_valid[d]), 32'd0);
    endtask

    task automatic run_op(int d, string nm, logic [15:0] x, logic [15:0] y, logic cin, logic s,
                          logic [15:0] ef, logic ec, logic eo);
        issue(d, x, y, cin, s);
        wait_valid(d, nm, ef, ec, eo);
        handoff(d, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        c0_in     = '0;
        sub_in    = '0;
        a_in      = '0;
        b_in      = '0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'b11);
        check("rst_out_valid", 32'(out_valid), 32'b00);
        check("rst_f0", 32'(f0), 32'd0);
        check("rst_c_ovf", 32'({c_out, ovf}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'b11);
        check("post_rst_f0", 32'(f0), 32'd0);

        run_op(0, "ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        run_op(0, "ripple", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Backpressure: result held for 5 cycles while other operands are offered.
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_valid(0, "ovf_pos", 16'h8000, 1'b0, 1'b1);
        a_in[0]  = 16'h1111;
        b_in[0]  = 16'h2222;
        c0_in[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = (i % 2 == 0);
            @(posedge clk); #1;
            check("bp_f", 32'(f0), 32'h8000);
            check("bp_c_ovf", 32'({c_out[0], ovf[0]}), 32'b01);
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
        end
        // Handoff with in_valid held: not accepted on the handoff edge, accepted on the next.
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("bp_handoff_in_ready", 32'(in_ready[0]), 32'd1);
        check("bp_handoff_f_held", 32'(f0), 32'h8000);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("bp_reaccept_in_ready", 32'(in_ready[0]), 32'd0);
        wait_valid(0, "held_op", 16'h3333, 1'b0, 1'b0);
        handoff(0, "held_op");

        // Reset during chunk 2.
        issue(0, 16'hABCD, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_out_valid", 32'(out_valid[0]), 32'd0);
        check("midrun_f", 32'(f0), 32'd0);
        check("midrun_in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, "after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Single-chunk instance.
        run_op(1, "n1_8080", 16'h0080, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op(1, "n1_7f01", 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1);
        run_op(1, "n1_ff00c", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        if (SUB_EN) begin
            run_op(0, "sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
            run_op(0, "sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
            run_op(1, "n1_sub_10_3", 16'h0010, 16'h0003, 1'b0, 1'b1, 16'h000D, 1'b1, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunk_serial_adder.md
# chunk_serial_adder

Parametrised multi-cycle adder that generalises the team's 4-bit ripple-carry adder (A, B, C0 → F, C4) to WIDTH-bit operands. It processes CHUNK bits per clock, LSB chunk first, with a registered carry between chunks. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Optional subtract mode is compiled in by macro.

## Interface
- WIDTH, 16, operand/result width; must be an exact multiple of CHUNK.
- CHUNK, 4, bits added per cycle; N = WIDTH/CHUNK cycles per operation.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, c0 (and sub) are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c0  input  1  carry-in.
- sub  input  1  subtract select; port present only with ADDER_SUB_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- f  output  WIDTH  sum/difference.
- c_out  output  1  carry out of the MSB.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. One clock domain; reset is asynchronous and active-low (rst_n).
- IDLE: in_ready = 1. On in_valid && in_ready:
  - latch a, b into operand registers;
  - carry register ← c0;
  - chunk index k ← 0;
  - go to RUN.
- RUN: each cycle, {carry, f[k*CHUNK +: CHUNK]} ← a_chunk + b_chunk + carry, then k ← k+1.
  - The carry into the MSB is captured on the last chunk for ovf.
  - After chunk N-1: c_out ← final carry, ovf ← captured MSB carry-in XOR final carry, go to DONE.
- DONE: out_valid = 1. f, c_out and ovf are held stable until out_ready = 1, then go to IDLE.
- in_valid outside IDLE is ignored; there is no queuing.
- N = 1 (CHUNK = WIDTH) is legal: RUN lasts exactly one cycle.
- Arithmetic is unsigned modulo 2^WIDTH. ovf interprets operands as two's complement.
- f is cleared to 0 on acceptance of a new operation.

## Timing
- Reset values (while rst_n low and immediately after release): state IDLE, in_ready 1, out_valid 0, f 0, c_out 0, ovf 0, k 0, carry 0.
- Latency: for an accept on edge T, chunk j is written at edge T+1+j. out_valid is high from edge T+N.
- in_ready falls at edge T.
- For a result taken on edge D (out_valid && out_ready), out_valid falls and in_ready rises at edge D.
- A new accept is possible at edge D+1 at the earliest. Throughput is one operation per N+1 cycles with out_ready held high.
- out_ready is sampled only in DONE.
- Simultaneous in_valid and out_ready in DONE: the result is handed off, the new operand is not accepted, and in_valid must be held.
- Reset mid-RUN or mid-DONE: the operation is aborted immediately (asynchronous), outputs go to their reset values, and the partial result is discarded.

## Configuration
- ADDER_SUB_EN defined:
  - The sub port exists and is latched with the operands.
  - sub = 1 computes a + ~b + 1: b is inverted at latch time and the carry register is forced to 1, so c0 is ignored.
  - c_out = 1 means no borrow. ovf is signed subtraction overflow.
- ADDER_SUB_EN undefined: there is no sub port, and the block is add-only.

## Test plan
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0xFFFF, c0=0 → f=0xFFFE, c_out=1, ovf=0; out_valid rises exactly 4 edges after accept.
- a=0x7FFF, b=0x0001, c0=0 → f=0x8000, c_out=0, ovf=1. Also a=0x0FFF, b=0x0000, c0=1 → f=0x1000; checks carry ripple across all chunk boundaries.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid → f, c_out and ovf stay stable, in_ready=0, and the extra operands are never processed. Then out_ready=1 → in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 during chunk 2 → out_valid=0, f=0 and in_ready=1 immediately. After release, a=0x1234 + b=0x4321 → f=0x5555.
- WIDTH=8, CHUNK=8 (N=1): a=0x80, b=0x80 → f=0x00, c_out=1, ovf=1, out_valid 1 edge after accept.
- ADDER_SUB_EN, WIDTH=16, CHUNK=4:
  - a=0x0005, sub=1, b=0x0007, c0=0 → f=0xFFFE, c_out=0, ovf=0.
  - a=0x8000, sub=1, b=0x0001 → f=0x7FFF, c_out=1, ovf=1.
